// File: rtl/nios2_oci_trace_collector.sv
// Data-trace collector: captures {dct_count, dct_buffer} words into a FIFO and
// drains them through a first-word-fall-through valid/ready port.
module nios2_oci_trace_collector #(
    parameter int DCT_W      = 30,
    parameter int CNT_W      = 4,
    parameter int DEPTH      = 16,
    parameter int WRAP_MODE  = 0,
    parameter int DROP_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DCT_W-1:0]         dct_buffer,
    input  logic [CNT_W-1:0]         dct_count,
    input  logic                     dct_push,
    input  logic                     test_ending,
    input  logic                     test_has_ended,
    output logic [CNT_W+DCT_W-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [DROP_CNT_W-1:0]    drop_count,
    output logic                     overflow,
    output logic [1:0]               state,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = CNT_W + DCT_W;
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_LVL  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [AW:0]           fill_q, fill_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  ovf_q, ovf_d;
    logic [W-1:0]          data_q, data_d;
    logic                  valid_q, valid_d;
    logic [W-1:0]          mem [DEPTH];

    logic [W-1:0] word;
    logic [W-1:0] head;
    logic         validPush;
    logic         endReq;
    logic         pop;
    logic         full;
    logic         accepting;
    logic         wrEn;
    logic         overwrite;
    logic         dropEv;

    assign word      = {dct_count, dct_buffer};
    assign validPush = dct_push && (dct_count != '0);
    assign endReq    = test_ending || test_has_ended;
    assign pop       = valid_q && out_ready;
    assign full      = (fill_q == FULL_LVL);
    assign accepting = (state_q == ST_IDLE) || (state_q == ST_CAPTURE);

    // A word written this cycle may already be the new head (empty FIFO, or
    // popping the last entry), so the head bypasses the array in that case.
    always_comb begin
        wrEn      = 1'b0;
        overwrite = 1'b0;
        dropEv    = 1'b0;
        state_d   = state_q;
        fill_d    = fill_q;
        drop_d    = drop_q;
        ovf_d     = ovf_q;

        if (validPush && accepting) begin
            if (!full || pop) begin
                wrEn = 1'b1;
            end else if (WRAP_MODE != 0) begin
                wrEn      = 1'b1;
                overwrite = 1'b1;
                dropEv    = 1'b1;
            end else begin
                dropEv = 1'b1;
            end
        end

        wptr_d = wrEn ? (wptr_q + ONE_PTR) : wptr_q;
        rptr_d = (pop || overwrite) ? (rptr_q + ONE_PTR) : rptr_q;

        if (wrEn && !pop && !overwrite) begin
            fill_d = fill_q + ONE_LVL;
        end else if (pop && !wrEn) begin
            fill_d = fill_q - ONE_LVL;
        end

        if (dropEv) begin
            ovf_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + DROP_CNT_W'(1);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (endReq) begin
                    state_d = ST_FLUSH;
                end else if (validPush) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (endReq) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fill_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_DONE;
        endcase

        head    = (wrEn && (wptr_q == rptr_d)) ? word : mem[rptr_d];
        valid_d = (fill_d != '0) && (state_d != ST_DONE);
        data_d  = valid_d ? head : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fill_q  <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fill_q  <= fill_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wrEn) begin
            mem[wptr_q] <= word;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign fill_level = fill_q;
    assign drop_count = drop_q;
    assign overflow   = ovf_q;
    assign state      = state_q;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_nios2_oci_trace_collector.sv
// Bench for the trace collector: one instance per overflow mode, each with a
// queue-based reference model and a pop-driven scoreboard monitor.
module tb_nios2_oci_trace_collector;

    localparam int DCT_W = 30;
    localparam int CNT_W = 4;
    localparam int DEPTH = 16;
    localparam int W     = CNT_W + DCT_W;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1;
    logic             dctPush = 1'b0;
    logic             testEnding = 1'b0;
    logic             testHasEnded = 1'b0;
    logic             outReady = 1'b0;
    logic [DCT_W-1:0] dctBuffer = '0;
    logic [CNT_W-1:0] dctCount = '0;

    logic [W-1:0]  outData   [2];
    logic          outValid  [2];
    logic [LW-1:0] fillLevel [2];
    logic [15:0]   dropCount [2];
    logic          overflowO [2];
    logic [1:0]    stateO    [2];
    logic          doneO     [2];

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    task automatic checkOutput(input string name, input int mode,
                               input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s mode=%0d actual=0x%0h required=0x%0h t=%0t",
                     name, mode, act, exp, $time);
        end
    endtask

    // Mode 0 stops on full, mode 1 overwrites the oldest entry.
    for (genvar m = 0; m < 2; m++) begin : gMode
        logic [W-1:0] expQ[$];
        int           mState = 0;
        int unsigned  drops = 0;
        bit           mOvf = 1'b0;
        bit           popPend = 1'b0;
        int           popCount = 0;
        int           preFill;
        bit           vPush;
        bit           endReq;
        logic [W-1:0] got;
        logic [W-1:0] want;

        nios2_oci_trace_collector #(
            .DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH),
            .WRAP_MODE(m), .DROP_CNT_W(16)
        ) dut (
            .clk(clk),
            .reset(reset),
            .dct_buffer(dctBuffer),
            .dct_count(dctCount),
            .dct_push(dctPush),
            .test_ending(testEnding),
            .test_has_ended(testHasEnded),
            .out_data(outData[m]),
            .out_valid(outValid[m]),
            .out_ready(outReady),
            .fill_level(fillLevel[m]),
            .drop_count(dropCount[m]),
            .overflow(overflowO[m]),
            .state(stateO[m]),
            .done(doneO[m])
        );

        // Reference model: the FIFO is a plain queue; the monitor removes
        // popped words, so popPend restores the pre-pop occupancy.
        always @(posedge clk) begin
            if (reset) begin
                expQ.delete();
                mState  = 0;
                drops   = 0;
                mOvf    = 1'b0;
                popPend = 1'b0;
            end else begin
                preFill = expQ.size() + (popPend ? 1 : 0);
                vPush   = dctPush && (dctCount != 0);
                endReq  = testEnding || testHasEnded;
                if (vPush && (mState == 0 || mState == 1)) begin
                    if (expQ.size() < DEPTH) begin
                        expQ.push_back({dctCount, dctBuffer});
                    end else begin
                        if (m == 1) begin
                            void'(expQ.pop_front());
                            expQ.push_back({dctCount, dctBuffer});
                        end
                        if (drops < 65535) drops++;
                        mOvf = 1'b1;
                    end
                end
                case (mState)
                    0: mState = endReq ? 2 : (vPush ? 1 : 0);
                    1: mState = endReq ? 2 : 1;
                    2: mState = (preFill == 0) ? 3 : 2;
                    default: mState = 3;
                endcase
                popPend = 1'b0;
            end
        end

        always @(negedge clk) begin
            if (armed) begin
                checkOutput("out_valid", m, 64'(outValid[m]),
                            64'(expQ.size() != 0 && mState != 3));
                checkOutput("fill_level", m, 64'(fillLevel[m]), 64'(expQ.size()));
                checkOutput("drop_count", m, 64'(dropCount[m]), 64'(drops));
                checkOutput("overflow", m, 64'(overflowO[m]), 64'(mOvf));
                checkOutput("state", m, 64'(stateO[m]), 64'(mState));
                checkOutput("done", m, 64'(doneO[m]), 64'(mState == 3));
                if (!reset && outValid[m] === 1'b1 && outReady) begin
                    got = outData[m];
                    if (expQ.size() == 0) begin
                        checkOutput("pop_on_empty", m, 64'(got), 64'(0));
                        checkOutput("pop_on_empty_q", m, 64'(1), 64'(0));
                    end else begin
                        want = expQ.pop_front();
                        checkOutput("pop_data", m, 64'(got), 64'(want));
                        popPend = 1'b1;
                        popCount++;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input bit push, input logic [CNT_W-1:0] cnt,
                                 input logic [DCT_W-1:0] data, input bit rdy,
                                 input bit tEnd, input bit tHas, input bit rst);
        dctPush      = push;
        dctCount     = cnt;
        dctBuffer    = data;
        outReady     = rdy;
        testEnding   = tEnd;
        testHasEnded = tHas;
        reset        = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pc0;
        int pc1;
        repeat (2) @(posedge clk);
        #1;
        armed = 1'b1;

        // Zero-count pushes are invisible even in IDLE.
        applyStimulus(1, 4'h0, 30'h123, 1, 0, 0, 0);
        checkOutput("zero_state", 0, 64'(stateO[0]), 64'(0));
        checkOutput("zero_fill", 0, 64'(fillLevel[0]), 64'(0));
        checkOutput("zero_drop", 0, 64'(dropCount[0]), 64'(0));

        applyStimulus(1, 4'h3, 30'h0000ABC, 1, 0, 0, 0);
        checkOutput("basic_state", 0, 64'(stateO[0]), 64'(1));
        checkOutput("basic_valid", 0, 64'(outValid[0]), 64'(1));
        checkOutput("basic_data", 0, 64'(outData[0]), {30'h0, 4'h3, 30'h0000ABC});
        applyStimulus(0, 4'h0, 30'h0, 1, 0, 0, 0);
        checkOutput("basic_fill", 0, 64'(fillLevel[0]), 64'(0));

        // Overflow: 20 pushes into a 16-deep FIFO with the consumer stalled.
        applyStimulus(0, 4'h0, 30'h0, 0, 0, 0, 1);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1, 4'((i % 15) + 1), 30'(i), 0, 0, 0, 0);
        end
        for (int m = 0; m < 2; m++) begin
            checkOutput("ovf_fill", m, 64'(fillLevel[m]), 64'(16));
            checkOutput("ovf_drop", m, 64'(dropCount[m]), 64'(4));
            checkOutput("ovf_flag", m, 64'(overflowO[m]), 64'(1));
        end
        checkOutput("ovf_head_stop", 0, 64'(outData[0][DCT_W-1:0]), 64'(1));
        checkOutput("ovf_head_wrap", 1, 64'(outData[1][DCT_W-1:0]), 64'(5));
        repeat (18) applyStimulus(0, 4'h0, 30'h0, 1, 0, 0, 0);

        // Refill to full, then push and pop together at full.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 4'h7, 30'(32'h100 + i), 0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 4'h9, 30'(32'h200 + i), 1, 0, 0, 0);
        end
        for (int m = 0; m < 2; m++) begin
            checkOutput("fullpp_fill", m, 64'(fillLevel[m]), 64'(16));
            checkOutput("fullpp_drop", m, 64'(dropCount[m]), 64'(4));
        end
        applyStimulus(1, 4'h2, 30'h3FF, 0, 0, 0, 1);
        for (int m = 0; m < 2; m++) begin
            checkOutput("rst_state", m, 64'(stateO[m]), 64'(0));
            checkOutput("rst_fill", m, 64'(fillLevel[m]), 64'(0));
            checkOutput("rst_valid", m, 64'(outValid[m]), 64'(0));
            checkOutput("rst_ovf", m, 64'(overflowO[m]), 64'(0));
        end

        // Flush: five queued, sixth arrives with test_ending.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, 4'h1, 30'(32'h40 + i), 0, 0, 0, 0);
        end
        applyStimulus(1, 4'h1, 30'h46, 0, 1, 0, 0);
        checkOutput("flush_state", 0, 64'(stateO[0]), 64'(2));
        checkOutput("flush_fill", 0, 64'(fillLevel[0]), 64'(6));
        pc0 = gMode[0].popCount;
        pc1 = gMode[1].popCount;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 4'h5, 30'($urandom), 1, 0, 0, 0);
        end
        checkOutput("flush_pops", 0, 64'(gMode[0].popCount - pc0), 64'(6));
        checkOutput("flush_pops", 1, 64'(gMode[1].popCount - pc1), 64'(6));
        checkOutput("flush_done", 0, 64'(doneO[0]), 64'(1));
        checkOutput("flush_done", 1, 64'(doneO[1]), 64'(1));

        // Randomised rounds with varying consumer stall pressure.
        for (int r = 0; r < 4; r++) begin
            applyStimulus(0, 4'h0, 30'h0, 0, 0, 0, 1);
            for (int c = 0; c < 200; c++) begin
                applyStimulus($urandom_range(0, 9) < 7,
                              4'($urandom_range(0, 15)),
                              30'($urandom),
                              $urandom_range(0, 3) < r,
                              $urandom_range(0, 299) == 0,
                              $urandom_range(0, 299) == 0,
                              0);
            end
            for (int c = 0; c < 40; c++) begin
                applyStimulus($urandom_range(0, 1) == 1, 4'($urandom_range(1, 15)),
                              30'($urandom), 1, 1, 0, 0);
            end
            checkOutput("rand_done", 0, 64'(doneO[0]), 64'(1));
            checkOutput("rand_done", 1, 64'(doneO[1]), 64'(1));
        end

        armed = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
